pc_sequencer: RTL and testbench

//  Parametrised program-counter unit for the multicycle datapath. Generalises the PC update to

---
 rtl/pc_pkg.sv | 20 ++
 rtl/ras_stack.sv | 63 ++++++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
//   PC_SEQ/PC_BR/PC_JR/PC_RET : next-PC select codes
//   ST_PC_UPD                 : control-FSM state in which the PC advances
//   sext()                    : sign-extend the low 'width' bits of a 64-bit value
package pc_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_RET = 2'b11;

    localparam logic [3:0] ST_PC_UPD = 4'b1000;

    function automatic logic [63:0] sext(input logic [63:0] val, input int width);
        logic [63:0] v_sh;
        v_sh = val << (64 - width);
        return $signed(v_sh) >>> (64 - width);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack as a circular buffer.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_push, i_pop    : push i_data / pop top; both together replace the top entry
//   i_data           : value to push
//   o_top            : current top entry (valid when !o_empty)
//   o_empty, o_full  : occupancy flags
// A push while full advances the pointer onto the oldest entry, overwriting it.
module ras_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_empty,
    output logic         o_full
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_top;
    logic [PW:0]   r_cnt;
    logic [PW-1:0] w_top_inc;
    logic [PW-1:0] w_top_dec;

    assign w_top_inc = r_top + 1'b1;
    assign w_top_dec = r_top - 1'b1;
    assign o_top     = r_mem[r_top];
    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (PW+1)'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_top <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    r_top            <= w_top_inc;
                    r_mem[w_top_inc] <= i_data;
                    if (!o_full) r_cnt <= r_cnt + 1'b1;
                end
                2'b01: begin
                    if (!o_empty) begin
                        r_top <= w_top_dec;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                2'b11: begin
                    // pop+push: replace in place, occupancy unchanged
                    r_mem[r_top] <= i_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit for the multicycle datapath.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_estado       : control-FSM state; PC updates only in UPD_STATE
//   i_stall        : blocks the update
//   i_pc_sel       : next-PC mode (seq / branch / jump-reg / return)
//   i_br_taken     : branch condition
//   i_immediate    : signed offset
//   i_rs1_val      : jump-reg base
//   i_push_ra      : push link address (PC+STEP)
//   o_pc, o_pc_prev: current PC and PC before the last committed update
//   o_upd, o_misalign, o_ras_uflow : one-cycle event pulses
//   o_ras_empty, o_ras_full        : return-address stack occupancy
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                 XLEN      = 32,
    parameter int                 IMM_W     = 12,
    parameter int                 STATE_W   = 4,
    parameter logic [STATE_W-1:0] UPD_STATE = STATE_W'(ST_PC_UPD),
    parameter bit                 BYTE_ADDR = 1'b0,
    parameter int                 RAS_DEPTH = 4,
    parameter logic [XLEN-1:0]    RESET_PC  = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [STATE_W-1:0] i_estado,
    input  logic               i_stall,
    input  logic [1:0]         i_pc_sel,
    input  logic               i_br_taken,
    input  logic [IMM_W-1:0]   i_immediate,
    input  logic [XLEN-1:0]    i_rs1_val,
    input  logic               i_push_ra,
    output logic [XLEN-1:0]    o_pc,
    output logic [XLEN-1:0]    o_pc_prev,
    output logic               o_upd,
    output logic               o_misalign,
    output logic               o_ras_empty,
    output logic               o_ras_full,
    output logic               o_ras_uflow
);

    localparam logic [XLEN-1:0] STEP = BYTE_ADDR ? XLEN'(4) : XLEN'(1);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_prev;
    logic            r_upd;
    logic            r_misalign;
    logic            r_uflow;

    logic [XLEN-1:0] w_sext;
    logic [XLEN-1:0] w_off;
    logic [XLEN-1:0] w_seq;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_pop;
    logic            w_uflow;
    logic            w_en;
    logic            w_mis;
    logic            w_commit;

    assign w_sext = XLEN'(sext(64'(i_immediate), IMM_W));
    // Word mode scales the byte offset down; arithmetic shift floors negatives.
    assign w_off  = BYTE_ADDR ? w_sext : XLEN'($signed(w_sext) >>> 2);
    assign w_seq  = r_pc + STEP;
    assign w_en   = (i_estado == UPD_STATE) && !i_stall;

    always_comb begin
        w_target = w_seq;
        w_pop    = 1'b0;
        w_uflow  = 1'b0;
        case (i_pc_sel)
            PC_SEQ: w_target = w_seq;
            PC_BR:  w_target = i_br_taken ? (r_pc + w_off) : w_seq;
            PC_JR:  w_target = i_rs1_val + w_off;
            PC_RET: begin
                if (!w_ras_empty) begin
                    w_target = w_ras_top;
                    w_pop    = 1'b1;
                end else begin
                    w_target = w_seq;
                    w_uflow  = 1'b1;
                end
            end
            default: w_target = w_seq;
        endcase
    end

    assign w_mis    = BYTE_ADDR && (w_target[1:0] != 2'b00);
    assign w_commit = w_en && !w_mis;

    ras_stack #(
        .W     (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_commit && i_push_ra),
        .i_pop   (w_commit && w_pop),
        .i_data  (w_seq),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (o_ras_full)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_pc_prev  <= RESET_PC;
            r_upd      <= 1'b0;
            r_misalign <= 1'b0;
            r_uflow    <= 1'b0;
        end else begin
            r_upd      <= w_commit;
            r_misalign <= w_en && w_mis;
            r_uflow    <= w_en && w_uflow;
            if (w_commit) begin
                r_pc      <= w_target;
                r_pc_prev <= r_pc;
            end
        end
    end

    assign o_pc        = r_pc;
    assign o_pc_prev   = r_pc_prev;
    assign o_upd       = r_upd;
    assign o_misalign  = r_misalign;
    assign o_ras_uflow = r_uflow;
    assign o_ras_empty = w_ras_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  estado;
    logic        stall;
    logic [1:0]  pc_sel;
    logic        br_taken;
    logic [11:0] imm;
    logic [31:0] rs1;
    logic        push_ra;

    logic [31:0] pc_o   [2];
    logic [31:0] prev_o [2];
    logic        upd_o  [2];
    logic        mis_o  [2];
    logic        emp_o  [2];
    logic        full_o [2];
    logic        uf_o   [2];

    int tests = 0;
    int fails = 0;

    // reference model state: index 0 = word-addressed unit, 1 = byte-addressed unit
    logic [31:0] m_pc   [2];
    logic [31:0] m_prev [2];
    logic [31:0] q_w [$];
    logic [31:0] q_b [$];
    logic        e_upd [2];
    logic        e_mis [2];
    logic        e_uf  [2];

    always #5 clk = ~clk;

    pc_sequencer #(.BYTE_ADDR(1'b0)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_estado(estado), .i_stall(stall),
        .i_pc_sel(pc_sel), .i_br_taken(br_taken), .i_immediate(imm),
        .i_rs1_val(rs1), .i_push_ra(push_ra),
        .o_pc(pc_o[0]), .o_pc_prev(prev_o[0]), .o_upd(upd_o[0]),
        .o_misalign(mis_o[0]), .o_ras_empty(emp_o[0]), .o_ras_full(full_o[0]),
        .o_ras_uflow(uf_o[0])
    );

    pc_sequencer #(.BYTE_ADDR(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_estado(estado), .i_stall(stall),
        .i_pc_sel(pc_sel), .i_br_taken(br_taken), .i_immediate(imm),
        .i_rs1_val(rs1), .i_push_ra(push_ra),
        .o_pc(pc_o[1]), .o_pc_prev(prev_o[1]), .o_upd(upd_o[1]),
        .o_misalign(mis_o[1]), .o_ras_empty(emp_o[1]), .o_ras_full(full_o[1]),
        .o_ras_uflow(uf_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int b);
        logic [31:0] pc, prev, tgt, stp;
        logic [31:0] q [$];
        int  s, off;
        logic do_pop, mis;
        pc = m_pc[b];
        prev = m_prev[b];
        if (b == 0) q = q_w; else q = q_b;
        e_upd[b] = 1'b0;
        e_mis[b] = 1'b0;
        e_uf[b]  = 1'b0;
        if (rst) begin
            pc = 32'd0;
            prev = 32'd0;
            q.delete();
        end else if (estado == 4'd8 && !stall) begin
            stp = (b == 1) ? 32'd4 : 32'd1;
            s = imm[11] ? int'(imm) - 4096 : int'(imm);
            if (b == 1) off = s;
            else off = (s < 0) ? (s - 3) / 4 : s / 4;
            do_pop = 1'b0;
            case (pc_sel)
                2'd0: tgt = pc + stp;
                2'd1: tgt = br_taken ? pc + off : pc + stp;
                2'd2: tgt = rs1 + off;
                default: begin
                    if (q.size() > 0) begin
                        tgt = q[$];
                        do_pop = 1'b1;
                    end else begin
                        tgt = pc + stp;
                        e_uf[b] = 1'b1;
                    end
                end
            endcase
            mis = (b == 1) && (tgt[1:0] != 2'b00);
            e_mis[b] = mis;
            if (!mis) begin
                if (do_pop) void'(q.pop_back());
                if (push_ra) begin
                    q.push_back(pc + stp);
                    if (q.size() > 4) void'(q.pop_front());
                end
                prev = pc;
                pc = tgt;
                e_upd[b] = 1'b1;
            end
        end
        m_pc[b] = pc;
        m_prev[b] = prev;
        if (b == 0) q_w = q; else q_b = q;
    endtask

    task automatic check_all();
        string nm;
        int sz;
        for (int b = 0; b < 2; b++) begin
            nm = (b == 0) ? "w" : "b";
            sz = (b == 0) ? q_w.size() : q_b.size();
            check({nm, ".pc"},    pc_o[b],   m_pc[b]);
            check({nm, ".prev"},  prev_o[b], m_prev[b]);
            check({nm, ".upd"},   32'(upd_o[b]),  32'(e_upd[b]));
            check({nm, ".mis"},   32'(mis_o[b]),  32'(e_mis[b]));
            check({nm, ".uflow"}, 32'(uf_o[b]),   32'(e_uf[b]));
            check({nm, ".empty"}, 32'(emp_o[b]),  32'(sz == 0));
            check({nm, ".full"},  32'(full_o[b]), 32'(sz == 4));
        end
    endtask

    task automatic apply(input logic [3:0] e, input logic s, input logic [1:0] sel,
                         input logic br, input logic [11:0] im, input logic [31:0] r,
                         input logic p, input logic rs);
        @(negedge clk);
        estado = e; stall = s; pc_sel = sel; br_taken = br;
        imm = im; rs1 = r; push_ra = p; rst = rs;
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
        check_all();
    endtask

    task automatic op(input logic [1:0] sel, input logic br, input logic [11:0] im,
                      input logic [31:0] r, input logic p);
        apply(4'd8, 1'b0, sel, br, im, r, p, 1'b0);
    endtask

    initial begin
        rst = 1'b1; estado = 4'd0; stall = 1'b0; pc_sel = 2'd0;
        br_taken = 1'b0; imm = 12'd0; rs1 = 32'd0; push_ra = 1'b0;
        m_pc[0] = 32'd0; m_pc[1] = 32'd0; m_prev[0] = 32'd0; m_prev[1] = 32'd0;

        // reset state
        apply(4'd8, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b1);
        check("rst.pc", pc_o[0], 32'd0);
        check("rst.empty", 32'(emp_o[0]), 32'd1);

        // sequential updates
        op(2'd0, 0, 12'd0, 32'd0, 0); check("seq1", pc_o[0], 32'd1);
        op(2'd0, 0, 12'd0, 32'd0, 0); check("seq2", pc_o[0], 32'd2);
        op(2'd0, 0, 12'd0, 32'd0, 0); check("seq3", pc_o[0], 32'd3);
        check("seq3.prev", prev_o[0], 32'd2);

        // branches from PC=10
        op(2'd2, 0, 12'd0, 32'd10, 0);
        op(2'd1, 1, 12'hFF8, 32'd0, 0); check("br.m8", pc_o[0], 32'd8);
        op(2'd2, 0, 12'd0, 32'd10, 0);
        op(2'd1, 1, 12'hFFA, 32'd0, 0); check("br.m6floor", pc_o[0], 32'd8);
        op(2'd2, 0, 12'd0, 32'd10, 0);
        op(2'd1, 0, 12'hFF8, 32'd0, 0); check("br.nt", pc_o[0], 32'd11);

        // update blocked by state / stall, then reset wins over an enabled cycle
        apply(4'd7, 1'b0, 2'd1, 1'b1, 12'hFF8, 32'd0, 1'b1, 1'b0);
        check("hold.state", pc_o[0], 32'd11);
        apply(4'd8, 1'b1, 2'd1, 1'b1, 12'hFF8, 32'd0, 1'b1, 1'b0);
        check("hold.stall", pc_o[0], 32'd11);
        apply(4'd8, 1'b0, 2'd1, 1'b1, 12'hFF8, 32'd0, 1'b1, 1'b1);
        check("rst.prio", pc_o[0], 32'd0);

        // five calls into a four-deep stack, then returns
        op(2'd2, 0, 12'd0, 32'd10, 1);
        op(2'd2, 0, 12'd0, 32'd20, 1);
        op(2'd2, 0, 12'd0, 32'd30, 1);
        op(2'd2, 0, 12'd0, 32'd40, 1);
        op(2'd2, 0, 12'd0, 32'd50, 1);
        check("ras.full", 32'(full_o[0]), 32'd1);
        op(2'd3, 0, 12'd0, 32'd0, 0); check("ret1", pc_o[0], 32'd41);
        op(2'd3, 0, 12'd0, 32'd0, 0); check("ret2", pc_o[0], 32'd31);
        op(2'd3, 0, 12'd0, 32'd0, 0); check("ret3", pc_o[0], 32'd21);
        op(2'd3, 0, 12'd0, 32'd0, 0); check("ret4", pc_o[0], 32'd11);
        op(2'd3, 0, 12'd0, 32'd0, 0); check("ret5", pc_o[0], 32'd12);
        check("ret5.uflow", 32'(uf_o[0]), 32'd1);

        // byte-addressed alignment
        apply(4'd8, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b1);
        op(2'd2, 0, 12'd0, 32'h100, 0);
        op(2'd2, 0, 12'd0, 32'h202, 0);
        check("byte.mis", 32'(mis_o[1]), 32'd1);
        check("byte.hold", pc_o[1], 32'h100);
        op(2'd2, 0, 12'd4, 32'h200, 0); check("byte.jr", pc_o[1], 32'h204);

        // wrap-around and return+push
        apply(4'd8, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b1);
        op(2'd2, 0, 12'd0, 32'h4F, 0);
        op(2'd2, 0, 12'd0, 32'hFFFF_FFFF, 1);
        op(2'd0, 0, 12'd0, 32'd0, 0); check("wrap", pc_o[0], 32'd0);
        op(2'd2, 0, 12'd0, 32'hFFFF_FFFF, 0);
        op(2'd3, 0, 12'd0, 32'd0, 1); check("retpush", pc_o[0], 32'h50);
        op(2'd3, 0, 12'd0, 32'd0, 0); check("retpush.top", pc_o[0], 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 1) == 0) r[1:0] = 2'b00;
            apply(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd8,
                  ($urandom_range(0, 3) == 0),
                  2'($urandom), 1'($urandom), 12'($urandom), r,
                  1'($urandom), ($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
